// File: rtl/intersection_pkg.sv
// Shared types and sizing helpers for the intersection controller.
package intersection_pkg;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    GREEN     = 3'd1,
    YELLOW    = 3'd2,
    WALK      = 3'd3,
    EMERGENCY = 3'd4
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold any duration value up to max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Elapsed-cycle counter for the current phase; done marks the last cycle of the phase.
module phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [CW-1:0] duration,
  output logic          done,
  output logic [CW-1:0] count
);

  assign done = (count == duration - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!done) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/intersection_controller.sv
// Round-robin intersection controller with exclusive pedestrian phase and emergency override.
// Optional macro INTERSECTION_EARLY_PED_EN: end GREEN early once MIN_GREEN_CYCLES have elapsed with a pending walk.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int NUM_APPROACHES   = 4,
  parameter int GREEN_CYCLES     = 30,
  parameter int YELLOW_CYCLES    = 5,
  parameter int ALLRED_CYCLES    = 2,
  parameter int WALK_CYCLES      = 5,
  parameter int MIN_GREEN_CYCLES = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              emergency,
  input  logic [NUM_APPROACHES-1:0]         ped_request,
  output logic [NUM_APPROACHES-1:0]         red,
  output logic [NUM_APPROACHES-1:0]         yellow,
  output logic [NUM_APPROACHES-1:0]         green,
  output logic [NUM_APPROACHES-1:0]         walk,
  output logic [NUM_APPROACHES-1:0]         dont_walk,
  output logic [$clog2(NUM_APPROACHES)-1:0] active_approach
);

  localparam int MAX_DUR = max_of(max_of(GREEN_CYCLES, YELLOW_CYCLES),
                                  max_of(ALLRED_CYCLES, WALK_CYCLES));
  localparam int CW = cnt_width(MAX_DUR);
  localparam int IW = $clog2(NUM_APPROACHES);

  if (NUM_APPROACHES < 2 || NUM_APPROACHES > 8) begin : g_bad_num
    $error("NUM_APPROACHES must be 2..8");
  end
  if (MIN_GREEN_CYCLES < 1 || MIN_GREEN_CYCLES > GREEN_CYCLES) begin : g_bad_min
    $error("MIN_GREEN_CYCLES must be 1..GREEN_CYCLES");
  end

  state_t                    state;
  state_t                    next_state;
  logic [IW-1:0]             idx;
  logic [NUM_APPROACHES-1:0] ped_pending;
  logic [NUM_APPROACHES-1:0] walk_mask;
  logic                      walk_served;
  logic [CW-1:0]             duration;
  logic [CW-1:0]             count;
  logic                      done;
  logic                      clear;
  logic                      green_end;

  logic walk_enter;
  logic walk_exit;
  logic walk_abort;
  logic green_enter;
  logic yellow_exit;

  assign walk_enter  = (state == ALL_RED) && (next_state == WALK);
  assign walk_exit   = (state == WALK) && (next_state == ALL_RED);
  assign walk_abort  = (state == WALK) && (next_state == EMERGENCY);
  assign green_enter = (state == ALL_RED) && (next_state == GREEN);
  assign yellow_exit = (state == YELLOW) && (next_state == ALL_RED);

  // The counter restarts on every state entry and is pinned at zero during EMERGENCY.
  assign clear = (next_state != state) || (state == EMERGENCY);

  always_comb begin
    duration = CW'(1);
    case (state)
      ALL_RED: duration = CW'(ALLRED_CYCLES);
      GREEN:   duration = CW'(GREEN_CYCLES);
      YELLOW:  duration = CW'(YELLOW_CYCLES);
      WALK:    duration = CW'(WALK_CYCLES);
      default: duration = CW'(1);
    endcase
  end

  phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .duration(duration),
    .done    (done),
    .count   (count)
  );

`ifdef INTERSECTION_EARLY_PED_EN
  assign green_end = done || ((|ped_pending) && ((int'(count) + 1) >= MIN_GREEN_CYCLES));
`else
  assign green_end = done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ALL_RED;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (emergency) begin
      next_state = EMERGENCY;
    end else begin
      case (state)
        ALL_RED:   if (done) next_state = ((|ped_pending) && !walk_served) ? WALK : GREEN;
        GREEN:     if (green_end) next_state = YELLOW;
        YELLOW:    if (done) next_state = ALL_RED;
        WALK:      if (done) next_state = ALL_RED;
        EMERGENCY: next_state = ALL_RED;
        default:   next_state = ALL_RED;
      endcase
    end
  end

  // New requests always latch, so a request in the WALK entry cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      ped_pending <= '0;
      walk_mask   <= '0;
      walk_served <= 1'b0;
    end else begin
      if (walk_enter) begin
        walk_mask   <= ped_pending;
        ped_pending <= ped_request;
      end else if (walk_abort) begin
        walk_mask   <= '0;
        ped_pending <= ped_pending | walk_mask | ped_request;
      end else begin
        ped_pending <= ped_pending | ped_request;
      end

      if (walk_exit) begin
        walk_served <= 1'b1;
      end else if (walk_abort || green_enter) begin
        walk_served <= 1'b0;
      end

      if (yellow_exit) begin
        idx <= (idx == IW'(NUM_APPROACHES - 1)) ? '0 : idx + IW'(1);
      end
    end
  end

  always_comb begin
    red    = '1;
    yellow = '0;
    green  = '0;
    walk   = '0;
    case (state)
      GREEN: begin
        green[idx] = 1'b1;
        red[idx]   = 1'b0;
      end
      YELLOW: begin
        yellow[idx] = 1'b1;
        red[idx]    = 1'b0;
      end
      WALK:    walk = walk_mask;
      default: ;
    endcase
  end

  assign dont_walk       = ~walk;
  assign active_approach = idx;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed table-driven bench for intersection_controller (N=4, G=8, Y=3, AR=2, W=5, MIN=4).
module tb_intersection_controller;

  localparam int N    = 4;
  localparam int K_AR = 0;
  localparam int K_G  = 1;
  localparam int K_Y  = 2;
  localparam int K_W  = 3;
`ifdef INTERSECTION_EARLY_PED_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         emergency = 1'b0;
  logic [N-1:0] ped_request = '0;
  logic [N-1:0] red, yellow, green, walk, dont_walk;
  logic [1:0]   active_approach;

  int n_checks = 0;
  int n_fail   = 0;

  intersection_controller #(
    .NUM_APPROACHES  (4),
    .GREEN_CYCLES    (8),
    .YELLOW_CYCLES   (3),
    .ALLRED_CYCLES   (2),
    .WALK_CYCLES     (5),
    .MIN_GREEN_CYCLES(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .emergency      (emergency),
    .ped_request    (ped_request),
    .red            (red),
    .yellow         (yellow),
    .green          (green),
    .walk           (walk),
    .dont_walk      (dont_walk),
    .active_approach(active_approach)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] ped;
    logic       emg;
    int         cycles;
    int         kind;
    int         idx;
    logic [3:0] wmask;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, logic [3:0] ped, logic emg, int cycles,
                              int kind, int idx, logic [3:0] wmask);
    vec_t v;
    v.rst = rst; v.ped = ped; v.emg = emg; v.cycles = cycles;
    v.kind = kind; v.idx = idx; v.wmask = wmask;
    vecs.push_back(v);
  endfunction

  // {red, yellow, green, walk, dont_walk, active_approach}
  function automatic logic [21:0] expected(int kind, int idx, logic [3:0] wmask);
    logic [3:0] r, y, g, w;
    r = 4'hF; y = 4'h0; g = 4'h0; w = 4'h0;
    case (kind)
      K_G:     begin g[idx] = 1'b1; r[idx] = 1'b0; end
      K_Y:     begin y[idx] = 1'b1; r[idx] = 1'b0; end
      K_W:     w = wmask;
      default: ;
    endcase
    return {r, y, g, w, ~w, 2'(idx)};
  endfunction

  task automatic check(string name, logic [21:0] exp);
    logic [21:0] act;
    act = {red, yellow, green, walk, dont_walk, active_approach};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got r=%b y=%b g=%b w=%b dw=%b a=%0d, want r=%b y=%b g=%b w=%b dw=%b a=%0d",
               name, act[21:18], act[17:14], act[13:10], act[9:6], act[5:2], act[1:0],
               exp[21:18], exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1:0]);
    end
  endtask

  task automatic run_phase(string name, int n, int kind, int idx, logic [3:0] wmask);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_c%0d", name, k + 1), expected(kind, idx, wmask));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    ped_request = '0;
    emergency   = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    check("reset_values", expected(K_AR, 0, 4'h0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int g_rest;
    g_rest = EARLY ? 3 : 7;

    // Idle rotation through all approaches, wrapping back to approach 0.
    add(1, 4'h0, 0, 2, K_AR, 0, 4'h0);
    for (int a = 0; a < 4; a++) begin
      add(0, 4'h0, 0, 8, K_G, a, 4'h0);
      add(0, 4'h0, 0, 3, K_Y, a, 4'h0);
      add(0, 4'h0, 0, 2, K_AR, (a + 1) % 4, 4'h0);
    end
    add(0, 4'h0, 0, 8, K_G, 0, 4'h0);

    // Pedestrian request pulse in green[0] cycle 1.
    add(1, 4'h0, 0, 2, K_AR, 0, 4'h0);
    add(0, 4'h4, 0, 1, K_G, 0, 4'h0);
    add(0, 4'h0, 0, g_rest, K_G, 0, 4'h0);
    add(0, 4'h0, 0, 3, K_Y, 0, 4'h0);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 5, K_W, 1, 4'h4);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 8, K_G, 1, 4'h0);
    add(0, 4'h0, 0, 1, K_Y, 1, 4'h0);

    // Emergency raised in yellow[1] cycle 2 for 10 clocks.
    add(1, 4'h0, 0, 2, K_AR, 0, 4'h0);
    add(0, 4'h0, 0, 8, K_G, 0, 4'h0);
    add(0, 4'h0, 0, 3, K_Y, 0, 4'h0);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 8, K_G, 1, 4'h0);
    add(0, 4'h0, 0, 1, K_Y, 1, 4'h0);
    add(0, 4'h0, 1, 1, K_Y, 1, 4'h0);
    add(0, 4'h0, 1, 9, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 1, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 8, K_G, 1, 4'h0);
    add(0, 4'h0, 0, 1, K_Y, 1, 4'h0);

    // Emergency in WALK cycle 3; the interrupted walk is re-served in full.
    add(1, 4'h0, 0, 2, K_AR, 0, 4'h0);
    add(0, 4'h1, 0, 1, K_G, 0, 4'h0);
    add(0, 4'h0, 0, g_rest, K_G, 0, 4'h0);
    add(0, 4'h0, 0, 3, K_Y, 0, 4'h0);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 2, K_W, 1, 4'h1);
    add(0, 4'h0, 1, 1, K_W, 1, 4'h1);
    add(0, 4'h0, 1, 3, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 1, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 5, K_W, 1, 4'h1);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 1, K_G, 1, 4'h0);

    // Early termination: requests in green cycle 1 and green cycle 6.
    add(1, 4'h0, 0, 2, K_AR, 0, 4'h0);
    add(0, 4'h2, 0, 1, K_G, 0, 4'h0);
    add(0, 4'h0, 0, EARLY ? 3 : 7, K_G, 0, 4'h0);
    add(0, 4'h0, 0, 3, K_Y, 0, 4'h0);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 5, K_W, 1, 4'h2);
    add(0, 4'h0, 0, 2, K_AR, 1, 4'h0);
    add(0, 4'h0, 0, 5, K_G, 1, 4'h0);
    add(0, 4'h1, 0, 1, K_G, 1, 4'h0);
    add(0, 4'h0, 0, EARLY ? 1 : 2, K_G, 1, 4'h0);
    add(0, 4'h0, 0, 1, K_Y, 1, 4'h0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      ped_request = vecs[i].ped;
      emergency   = vecs[i].emg;
      run_phase($sformatf("vec%0d", i), vecs[i].cycles, vecs[i].kind, vecs[i].idx, vecs[i].wmask);
    end

    // Asynchronous reset mid-GREEN between edges drops the pending request.
    do_reset();
    run_phase("arst_ar", 2, K_AR, 0, 4'h0);
    ped_request = 4'h4;
    run_phase("arst_g0a", 1, K_G, 0, 4'h0);
    ped_request = 4'h0;
    run_phase("arst_g0b", 1, K_G, 0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_immediate", expected(K_AR, 0, 4'h0));
    @(posedge clk);
    #1;
    check("arst_held", expected(K_AR, 0, 4'h0));
    rst_n = 1'b1;
    run_phase("arst_post_ar", 2, K_AR, 0, 4'h0);
    run_phase("arst_post_g0", 8, K_G, 0, 4'h0);
    run_phase("arst_post_y0", 3, K_Y, 0, 4'h0);
    run_phase("arst_post_ar1", 2, K_AR, 1, 4'h0);
    run_phase("arst_post_g1", 1, K_G, 1, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
